// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, STEP bits per clock, LSB slice first.
// The borrow is carried between slices in borrow_reg; diff/borrow/ovf are loaded
// only on the edge that completes the last slice, and they hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Reject parameter sets that cannot be split into whole slices.
    generate
        if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_subtractor: STEP must be >= 1 and divide WIDTH evenly");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;        // minuend, shifted right one slice per step
    logic [WIDTH-1:0] b_sh;        // subtrahend, shifted right one slice per step
    logic [WIDTH-1:0] res_sh;      // result slices enter at the top and move down
    logic             a_msb;       // original sign bits, kept for the overflow test
    logic             b_msb;
    logic             borrow_reg;
    logic [CW-1:0]    cnt;

    logic [STEP:0]    slice;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // One slice of the subtraction; the extra top bit is the borrow out of the slice.
    always_comb begin
        slice = {1'b0, a_sh[STEP-1:0]} - {1'b0, b_sh[STEP-1:0]} - {{STEP{1'b0}}, borrow_reg};
    end

    // After the final slice the newest bits land in the MSB position, so res_next is the full diff.
    generate
        if (WIDTH == STEP) begin : g_single
            assign res_next = slice[STEP-1:0];
        end else begin : g_multi
            assign res_next = {slice[STEP-1:0], res_sh[WIDTH-1:STEP]};
        end
    endgenerate

    // Overflow only possible when the operand signs differ.
    assign ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);

    // Control FSM and datapath registers; accepting from DONE gives back-to-back operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh       <= a;
                        b_sh       <= b;
                        res_sh     <= '0;
                        a_msb      <= a[WIDTH-1];
                        b_msb      <= b[WIDTH-1];
                        borrow_reg <= bin;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh       <= a_sh >> STEP;
                    b_sh       <= b_sh >> STEP;
                    res_sh     <= res_next;
                    borrow_reg <= slice[STEP];
                    cnt        <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        diff   <= res_next;
                        borrow <= slice[STEP];
                        ovf    <= ovf_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (8/1, 1/1, 8/4), each with an
// expected-result queue filled by the stimulus and drained by a done-driven monitor.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0]  d;
        logic        br;
        logic        o;
        logic [31:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Cycle stamp used to check done latency
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: WIDTH=8 STEP=1
    logic       start0 = 1'b0, bin0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       busy0, done0, borrow0, ovf0;
    logic [7:0] diff0;
    // DUT 1: WIDTH=1 STEP=1
    logic       start1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, borrow1, ovf1;
    logic [0:0] diff1;
    // DUT 2: WIDTH=8 STEP=4
    logic       start2 = 1'b0, bin2 = 1'b0;
    logic [7:0] a2 = '0, b2 = '0;
    logic       busy2, done2, borrow2, ovf2;
    logic [7:0] diff2;

    serial_subtractor #(.WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .bin(bin0),
        .busy(busy0), .done(done0), .diff(diff0), .borrow(borrow0), .ovf(ovf0));
    serial_subtractor #(.WIDTH(1), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .ovf(ovf1));
    serial_subtractor #(.WIDTH(8), .STEP(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2));

    exp_t q0[$], q1[$], q2[$];
    exp_t m0, m1, m2;
    int   n0 = 0;
    logic [7:0] last_diff = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic push(input int which, input logic [7:0] d, input logic br,
                        input logic o, input logic [31:0] t);
        exp_t e;
        e.d = d; e.br = br; e.o = o; e.t = t;
        if (which == 0) q0.push_back(e);
        else if (which == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // Monitors: pop and compare whenever a DUT presents done
    always @(negedge clk) begin
        if (done0) begin
            n0++;
            if (q0.size() == 0) chk("u0_unexpected_done", 32'(diff0), 32'hFFFF_FFFF);
            else begin
                m0 = q0.pop_front();
                chk("u0_result", {diff0, borrow0, ovf0}, {m0.d, m0.br, m0.o});
                chk("u0_done_cycle", cyc, m0.t);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) chk("u1_unexpected_done", 32'(diff1), 32'hFFFF_FFFF);
            else begin
                m1 = q1.pop_front();
                chk("u1_result", {diff1, borrow1, ovf1}, {m1.d[0], m1.br, m1.o});
                chk("u1_done_cycle", cyc, m1.t);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) chk("u2_unexpected_done", 32'(diff2), 32'hFFFF_FFFF);
            else begin
                m2 = q2.pop_front();
                chk("u2_result", {diff2, borrow2, ovf2}, {m2.d, m2.br, m2.o});
                chk("u2_done_cycle", cyc, m2.t);
            end
        end
    end

    // Single isolated operation on the 8/1 instance
    task automatic op0(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a0 = ta; b0 = tb; bin0 = tbin; start0 = 1'b1;
        push(0, ed, eb, eo, cyc + 9);
        @(negedge clk);
        start0 = 1'b0;
        chk("u0_busy_after_accept", 32'(busy0), 32'd1);
        chk("u0_diff_hold_in_run", 32'(diff0), 32'(last_diff));
        repeat (8) @(negedge clk);
        chk("u0_busy_low_at_done", 32'(busy0), 32'd0);
        @(negedge clk);
        last_diff = ed;
    endtask

    task automatic op1(input logic ta, input logic tb, input logic ed, input logic eb,
                       input logic eo);
        @(negedge clk);
        a1 = ta; b1 = tb; bin1 = 1'b0; start1 = 1'b1;
        push(1, {7'd0, ed}, eb, eo, cyc + 2);
        @(negedge clk);
        start1 = 1'b0;
        chk("u1_busy_after_accept", 32'(busy1), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic op2(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a2 = ta; b2 = tb; bin2 = tbin; start2 = 1'b1;
        push(2, ed, eb, eo, cyc + 3);
        @(negedge clk);
        start2 = 1'b0;
        chk("u2_busy_after_accept", 32'(busy2), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nd;
        logic [7:0] ops_a [3];
        logic [7:0] ops_b [3];
        logic       ops_c [3];
        logic [7:0] ops_d [3];
        logic       ops_br[3];
        logic       ops_o [3];

        // Power-up reset, checked before any clock edge
        #1 rst = 1'b1;
        #1 chk("u0_powerup_reset", {busy0, done0, diff0, borrow0, ovf0}, 32'd0);
        chk("u2_powerup_reset", {busy2, done2, diff2, borrow2, ovf2}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic and boundary operations
        op0(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op0(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op0(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op0(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        op0(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Asynchronous reset in the middle of an operation; no done may follow
        @(negedge clk);
        a0 = 8'h55; b0 = 8'h11; bin0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("u0_async_reset_midrun", {busy0, done0, diff0, borrow0, ovf0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = n0;
        repeat (12) @(negedge clk);
        chk("u0_no_done_after_abort", n0, nd);
        last_diff = 8'h00;

        // start held high, operands scrambled during RUN, new op taken on the DONE edge
        ops_a = '{8'h10, 8'h01, 8'h80};
        ops_b = '{8'h01, 8'h02, 8'h7F};
        ops_c = '{1'b0, 1'b1, 1'b1};
        ops_d = '{8'h0F, 8'hFE, 8'h00};
        ops_br = '{1'b0, 1'b1, 1'b0};
        ops_o = '{1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a0 = ops_a[k]; b0 = ops_b[k]; bin0 = ops_c[k];
            push(0, ops_d[k], ops_br[k], ops_o[k], cyc + 9);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                a0 = 8'($urandom); b0 = 8'($urandom); bin0 = 1'($urandom);
                if (k == 2 && i == 3) start0 = 1'b0;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // WIDTH=1: half-subtractor truth table
        op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // WIDTH=8 STEP=4: borrow carried between nibbles
        op2(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);
        op2(8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1, 1'b1);
        op2(8'h10, 8'h08, 1'b0, 8'h08, 1'b0, 1'b0);
        op2(8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0);

        // Every expected result must have been seen
        for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            @(negedge clk);
        chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case anything above stalls
    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running required finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor that computes diff = a - b - bin over WIDTH bits. It works STEP bits per clock, LSB first, and keeps the borrow in a register between steps. It is the sequential, width-generalised successor to the team's single-bit half subtractor. A start/busy/done handshake lets a controller issue operations and collect diff, borrow and signed overflow.

Parameters:
WIDTH, 8, operand and result width in bits (>= 1)
STEP, 1, bits processed per clock; must divide WIDTH evenly (checked by elaboration-time assertion)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on clk edge while not busy
a  input  WIDTH  minuend; captured on accepting edge
b  input  WIDTH  subtrahend; captured on accepting edge
bin  input  1  borrow-in; captured on accepting edge
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse; results valid
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
borrow  output  1  final borrow-out; 1 iff a < b + bin (unsigned)
ovf  output  1  signed overflow; 1 iff a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; internal operand and shift registers and borrow register cleared. Holds while rst=1.
- N = WIDTH/STEP.
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on edge E0 with start=1.
  - Capture a, b, bin.
  - Step counter = 0; internal borrow = bin; busy=1 after E0.
- RUN: edges E1..EN each process one STEP-bit slice, LSB slice first.
  - slice_diff = a_slice - b_slice - borrow_reg, computed as a (STEP+1)-bit subtraction.
  - The result slice is shifted into the internal result register.
  - borrow_reg = MSB of the (STEP+1)-bit result.
  - The counter increments.
- RUN to DONE: on edge EN, after the last slice.
  - diff, borrow and ovf load in the same edge; they are never updated at any other time.
  - busy=0, done=1.
- DONE to IDLE: on the next edge; done=0.
  - If start=1 on that edge, it is accepted exactly as from IDLE: back-to-back operation, state goes to RUN.
- Latency: done is high in the cycle after the N-th edge following the accepting edge. Throughput is one result per N+1 cycles.
- start while busy=1 (RUN) is ignored. Captured operands are unaffected; a, b and bin may change freely during RUN.
- diff, borrow and ovf hold their last values through IDLE and the following RUN until the next completion.
- Reset mid-operation: immediate abort to IDLE, all outputs 0. No done pulse is produced for the aborted operation.
- WIDTH=1, STEP=1: diff/borrow equal the half-subtractor truth table when bin=0.

Test Plan:
1. Reset: rst=1 mid-run and at power-up -> busy=0, done=0, diff=0x00, borrow=0, ovf=0 immediately (asynchronously, without a clock edge). No done pulse after rst falls.
2. WIDTH=8, STEP=1, a=0x05, b=0x03, bin=0, start pulse -> busy high for 8 cycles; done pulse 8 edges after accept; diff=0x02, borrow=0, ovf=0.
3. a=0x03, b=0x05, bin=0 -> diff=0xFE, borrow=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
4. a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1, ovf=0. a=0x7F, b=0xFF, bin=0 -> diff=0x80, borrow=1, ovf=1.
5. start held high continuously with operands changed mid-RUN -> mid-RUN starts ignored; results match operands captured at the accept edge; new op accepted on the DONE-cycle edge; done pulses every 9 cycles.
6. WIDTH=1, STEP=1, all four (a, b) with bin=0 -> diff/borrow = 00, 11, 10, 00 for ab = 00, 01, 10, 11; done 1 edge after accept. WIDTH=8, STEP=4, a=0xA5, b=0x5A -> diff=0x4B, borrow=0, ovf=1; done 2 edges after accept.
